// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the multi-word CLA sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/cla_seq_rr_arb.sv
// Two-way round-robin arbiter; on a tie it picks the requester that was not granted last.
// Latency: purely combinational, grant appears in the same cycle as valid.
// Backpressure: no grant while i_enable is low; the last-grant state is held by the parent.
module cla_seq_rr_arb
  import cla_seq_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant,
  output req_id_t    o_grant_id
);

  // Pick a winner: a lone requester wins outright, a tie goes to the other one.
  always_comb begin
    o_grant    = 2'b00;
    o_grant_id = 1'b0;
    if (i_enable) begin
      case (i_valid)
        2'b01: begin
          o_grant    = 2'b01;
          o_grant_id = 1'b0;
        end
        2'b10: begin
          o_grant    = 2'b10;
          o_grant_id = 1'b1;
        end
        2'b11: begin
          o_grant_id = ~i_last_grant;
          o_grant    = i_last_grant ? 2'b01 : 2'b10;
        end
        default: begin
          o_grant    = 2'b00;
          o_grant_id = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cla_word_sequencer.sv
// Time-shares one external 16-bit CLA slice across WORDS slices of a wide add/sub for two requesters.
// Latency: handshake cycle + WORDS RUN cycles, then result held in DONE (WORDS+2 cycles per op).
// Backpressure: result held stable until rsp_ready; no request accepted outside IDLE. Macro CLA_SEQ_ZFLAG_EN adds rsp_zero.
module cla_word_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [SLICE_W*WORDS-1:0] req0_a,
  input  logic [SLICE_W*WORDS-1:0] req0_b,
  input  logic                     req0_sub,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [SLICE_W*WORDS-1:0] req1_a,
  input  logic [SLICE_W*WORDS-1:0] req1_b,
  input  logic                     req1_sub,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [SLICE_W*WORDS-1:0] rsp_result,
  output logic                     rsp_cout,
  output logic                     rsp_ovf,
`ifdef CLA_SEQ_ZFLAG_EN
  output logic                     rsp_zero,
`endif
  output logic [SLICE_W-1:0]       slice_a,
  output logic [SLICE_W-1:0]       slice_b,
  output logic                     slice_cin,
  input  logic [SLICE_W-1:0]       slice_sum,
  input  logic                     slice_cout
);

  localparam int OPW   = SLICE_W * WORDS;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                          r_state;
  state_t                          w_state_nxt;
  req_id_t                         r_last_grant;
  req_id_t                         r_id;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_carry;
  logic [WORDS-1:0][SLICE_W-1:0]   r_a;
  logic [WORDS-1:0][SLICE_W-1:0]   r_b;
  logic [WORDS-1:0][SLICE_W-1:0]   r_res;

  logic [1:0]                      w_grant;
  req_id_t                         w_grant_id;
  logic                            w_arb_en;
  logic                            w_accept;
  logic                            w_last_word;
  logic                            w_done;
  logic [OPW-1:0]                  w_sel_a;
  logic [OPW-1:0]                  w_sel_b;
  logic                            w_sel_sub;

  // Arbitration is only offered in IDLE; gating with rst_n keeps ready low while reset is asserted.
  assign w_arb_en = (r_state == IDLE) & rst_n;

  cla_seq_rr_arb u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .i_enable     (w_arb_en),
    .o_grant      (w_grant),
    .o_grant_id   (w_grant_id)
  );

  // A grant is only issued to a valid requester, so a grant is the handshake.
  assign w_accept    = |w_grant;
  assign w_sel_a     = w_grant_id ? req1_a   : req0_a;
  assign w_sel_b     = w_grant_id ? req1_b   : req0_b;
  assign w_sel_sub   = w_grant_id ? req1_sub : req0_sub;
  assign w_last_word = (r_cnt == CNT_W'(WORDS - 1));
  assign w_done      = (r_state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus handshake and slice-drive outputs; everything idles at 0.
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    slice_a     = '0;
    slice_b     = '0;
    slice_cin   = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = w_grant[0];
        req1_ready = w_grant[1];
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        slice_a   = r_a[r_cnt];
        slice_b   = r_b[r_cnt];
        slice_cin = r_carry;
        if (w_last_word) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one slice result and the chained carry per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
    end else if ((r_state == IDLE) && w_accept) begin
      // Subtraction is a + ~b + 1: fold the inversion into the stored operand and the +1 into carry-in.
      r_a          <= w_sel_a;
      r_b          <= w_sel_b ^ {OPW{w_sel_sub}};
      r_carry      <= w_sel_sub;
      r_id         <= w_grant_id;
      r_last_grant <= w_grant_id;
      r_cnt        <= '0;
    end else if (r_state == RUN) begin
      r_res[r_cnt] <= slice_sum;
      r_carry      <= slice_cout;
      r_cnt        <= w_last_word ? '0 : r_cnt + 1'b1;
    end
  end

  // Response fields are only driven while the result is being offered.
  assign rsp_result = w_done ? r_res : '0;
  assign rsp_cout   = w_done & r_carry;
  assign rsp_id     = w_done & r_id;
  // Signed overflow: operands of equal sign produced a result of the other sign.
  assign rsp_ovf    = w_done
                    & (r_a[WORDS-1][SLICE_W-1] == r_b[WORDS-1][SLICE_W-1])
                    & (r_res[WORDS-1][SLICE_W-1] != r_a[WORDS-1][SLICE_W-1]);

`ifdef CLA_SEQ_ZFLAG_EN
  logic r_zero;

  // Zero flag built slice by slice so no wide compare sits on the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if ((r_state == IDLE) && w_accept) begin
      r_zero <= 1'b1;
    end else if (r_state == RUN) begin
      r_zero <= r_zero & (slice_sum == '0);
    end
  end

  assign rsp_zero = w_done & r_zero;
`endif

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer with WORDS=4 and a behavioural 16-bit CLA slice.
// Latency: checks accept-to-rsp_valid of WORDS+1 edges and result hold under rsp_ready backpressure.
// Backpressure: random rsp_ready stalls in DONE; requester operands scrambled after accept.
module tb_cla_word_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_sub = 1'b0, req1_sub = 1'b0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0]  rsp_result;
`ifdef CLA_SEQ_ZFLAG_EN
  logic          rsp_zero;
`endif
  logic [15:0]   slice_a, slice_b, slice_sum;
  logic          slice_cin, slice_cout;

  int n_chk  = 0;
  int n_pass = 0;
  logic mdl_last;

  cla_word_sequencer #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf),
`ifdef CLA_SEQ_ZFLAG_EN
    .rsp_zero   (rsp_zero),
`endif
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the external CLA slice.
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {16'd0, slice_cin};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp_valid"},  rsp_valid, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_rsp_cout"},   rsp_cout, 0);
    chk({tag, "_rsp_ovf"},    rsp_ovf, 0);
    chk({tag, "_rsp_id"},     rsp_id, 0);
    chk({tag, "_slice_a"},    slice_a, 0);
    chk({tag, "_slice_b"},    slice_b, 0);
    chk({tag, "_slice_cin"},  slice_cin, 0);
`ifdef CLA_SEQ_ZFLAG_EN
    chk({tag, "_rsp_zero"},   rsp_zero, 0);
`endif
  endtask

  // Present a request pattern, wait for the accept, predict the result and check the response.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                        input int hold);
    logic         pred, es;
    logic [W-1:0] ea, eb, beff, eres;
    logic [W:0]   full;
    logic         eco, eovf, got;
    int           cnt;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    #1;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < 10) begin
      if (req0_ready || req1_ready) got = 1'b1;
      else begin
        @(negedge clk); #1;
        cnt++;
      end
    end
    chk("accept_seen", got, 1);
    if (!got) return;
    chk("ready_onehot", req0_ready & req1_ready, 0);
    pred = (v0 && v1) ? ~mdl_last : v1;
    chk("grant_id", req1_ready, pred);
    mdl_last = pred;
    ea = pred ? a1 : a0;
    eb = pred ? b1 : b0;
    es = pred ? s1 : s0;
    beff = es ? ~eb : eb;
    full = {1'b0, ea} + {1'b0, beff} + {{W{1'b0}}, es};
    eres = full[W-1:0];
    eco  = full[W];
    eovf = (ea[W-1] == beff[W-1]) && (eres[W-1] != ea[W-1]);
    cnt = 0;
    do begin
      @(negedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_sub = ~req0_sub;
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_sub = ~req1_sub;
      end
      if (!rsp_valid) chk("ready_busy", req0_ready | req1_ready, 0);
    end while (!rsp_valid && cnt < 20);
    chk("latency", cnt, WORDS + 1);
    if (!rsp_valid) return;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk); #1;
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, pred);
      chk("rsp_result", rsp_result, eres);
      chk("rsp_cout", rsp_cout, eco);
      chk("rsp_ovf", rsp_ovf, eovf);
`ifdef CLA_SEQ_ZFLAG_EN
      chk("rsp_zero", rsp_zero, eres == '0);
`endif
      chk("done_ready", req0_ready | req1_ready, 0);
      chk("done_slice", {slice_cin, slice_a, slice_b}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_released", rsp_valid, 0);
    if (req0_valid || req1_valid) chk("reaccept_ready", req0_ready | req1_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   vm;
    mdl_last = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    run_op(1, 0, 64'h0000_0000_0000_FFFF, 64'h1, 0, 64'h0, 64'h0, 0, 0);
    run_op(0, 1, 64'h0, 64'h0, 0, 64'h0, 64'h1, 1, 0);
    run_op(1, 0, 64'h1234, 64'h1234, 1, 64'h0, 64'h0, 0, 0);
    run_op(0, 1, 64'h0, 64'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 1);
    run_op(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h0, 64'h0, 0, 3);

    // Reset in the second RUN cycle of an operation.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 64'h1111; req0_b = 64'h2222; req1_a = 64'h3333; req1_b = 64'h4444;
    #1;
    chk("pre_reset_accept", req0_ready | req1_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge clk); #1;
    chk("reset_no_rsp", rsp_valid, 0);
    rst_n = 1'b1;
    mdl_last = 1'b1;
    #1;
    chk("post_reset_rsp", rsp_valid, 0);
    for (int i = 0; i < 4; i++)
      run_op(1, 1, 64'h10 + i, 64'h1, 0, 64'h20 + i, 64'h2, 1, 0);

    for (int i = 0; i < 30; i++) begin
      vm = 2'($urandom_range(1, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ~ra;
        2: ra = {1'b0, {(W-1){1'b1}}};
        default: ;
      endcase
      run_op(vm[0], vm[1], ra, rb, 1'($urandom), rb, ra, 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
